run_monitor: RTL

//  Synthesizable run controller/monitor placed beside the SoC in simulation and FPGA builds.

---
 rtl/run_monitor_pkg.sv | 15 +
 rtl/run_mon_sat_counter.sv | 19 +
 rtl/run_monitor.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/run_monitor_pkg.sv
// Shared types and constants for the run monitor: FSM state encoding and the ebreak opcode.
package run_monitor_pkg;

    typedef enum logic [2:0] {
        S_RUN,
        S_DRAIN,
        S_RD,
        S_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic [31:0] OPC_EBREAK = 32'h0010_0073;

endpackage

// File: rtl/run_mon_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module run_mon_sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/run_monitor.sv
// Run controller: detects halt/timeout, waits a drain window, then dumps data memory over valid/ready.
// Optional RUN_MONITOR_TOHOST_EN adds a tohost-store end condition with pass/fail verdict.
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter logic [31:0]       HALT_INST      = OPC_EBREAK,
    parameter int unsigned       CNT_W          = 32,
    parameter int unsigned       TIMEOUT_CYCLES = 20000,
    parameter int unsigned       DRAIN_CYCLES   = 5,
    parameter int unsigned       DUMP_WORDS     = 20,
    parameter int unsigned       ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] DUMP_BASE      = '0
`ifdef RUN_MONITOR_TOHOST_EN
   ,parameter logic [ADDR_W-1:0] TOHOST_ADDR    = '0
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_valid,
    input  logic [31:0]       inst,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [31:0]       mem_rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [31:0]       dump_data,
    output logic [15:0]       dump_index,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              halted,
    output logic              timed_out,
`ifdef RUN_MONITOR_TOHOST_EN
    input  logic              st_en,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    output logic              pass,
    output logic              fail,
`endif
    output logic              done
);

    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]      DRAIN_LAST = 32'(DRAIN_CYCLES - 1);
    localparam logic [15:0]      LAST_IDX   = 16'(DUMP_WORDS - 1);

    state_t      state;
    logic [15:0] idx;
    logic [31:0] drain_cnt;
    logic        halt_hit;
    logic        tohost_hit;
    logic        stop_hit;
    logic        timeout_hit;

    always_comb begin
        halt_hit    = (state == S_RUN) && inst_valid && (inst == HALT_INST);
`ifdef RUN_MONITOR_TOHOST_EN
        tohost_hit  = (state == S_RUN) && st_en && (st_addr == TOHOST_ADDR);
`else
        tohost_hit  = 1'b0;
`endif
        stop_hit    = halt_hit || tohost_hit;
        timeout_hit = (TIMEOUT_CYCLES != 0) && (state == S_RUN) && (cycle_count == TO_LAST);
    end

    // The cycle that ends the run (halt or timeout) is not added to the count.
    run_mon_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk    (clk),
        .clear  (reset),
        .enable ((state == S_RUN) && !stop_hit && !timeout_hit),
        .count  (cycle_count)
    );

    run_mon_sat_counter #(.W(32)) u_drain_cnt (
        .clk    (clk),
        .clear  (reset || (state != S_DRAIN)),
        .enable (state == S_DRAIN),
        .count  (drain_cnt)
    );

    assign dump_index = idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_RUN;
            idx         <= '0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            dump_valid  <= 1'b0;
            dump_data   <= '0;
            halted      <= 1'b0;
            timed_out   <= 1'b0;
            done        <= 1'b0;
`ifdef RUN_MONITOR_TOHOST_EN
            pass        <= 1'b0;
            fail        <= 1'b0;
`endif
        end else begin
            mem_rd_en <= 1'b0;
            unique case (state)
                S_RUN: begin
                    if (stop_hit) begin
                        halted      <= halt_hit;
                        mem_rd_addr <= DUMP_BASE;
`ifdef RUN_MONITOR_TOHOST_EN
                        pass        <= tohost_hit && (st_data == 32'd1);
                        fail        <= tohost_hit && (st_data != 32'd1);
`endif
                        if (DRAIN_CYCLES == 0) begin
                            state     <= S_RD;
                            mem_rd_en <= 1'b1;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end else if (timeout_hit) begin
                        timed_out   <= 1'b1;
                        mem_rd_addr <= DUMP_BASE;
                        mem_rd_en   <= 1'b1;
                        state       <= S_RD;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        mem_rd_en <= 1'b1;
                        state     <= S_RD;
                    end
                end
                S_RD: state <= S_WAIT;
                S_WAIT: begin
                    dump_data  <= mem_rd_data;
                    dump_valid <= 1'b1;
                    state      <= S_OUT;
                end
                S_OUT: begin
                    if (dump_ready) begin
                        dump_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            idx         <= idx + 16'd1;
                            mem_rd_addr <= mem_rd_addr + ADDR_W'(4);
                            mem_rd_en   <= 1'b1;
                            state       <= S_RD;
                        end
                    end
                end
                S_DONE: state <= S_DONE;
                default: state <= S_RUN;
            endcase
        end
    end

endmodule
